// File: rtl/link_param_loader.sv
// Link parameter loader: accepts a valid/ready stream of packed per-link
// words {erased, boundary_condition, weight} and writes them into NUM_LINKS
// holding registers. The registers drive the link array's parameter buses
// and hold steady once loaded.
module link_param_loader #(
   parameter int NUM_LINKS   = 16,
   parameter int MAX_WEIGHT  = 2,
   parameter int STAGE_WIDTH = 3,
   parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE               = 3'd0,
   parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = 3'd7,
   localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
   localparam int WORD_W         = LINK_BIT_WIDTH + 3
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [STAGE_WIDTH-1:0]              global_stage,
   input  logic                                load_start,
   input  logic [WORD_W-1:0]                   in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_out,
   output logic [NUM_LINKS*2-1:0]              boundary_condition_out,
   output logic [NUM_LINKS-1:0]                erased_out,
   output logic                                load_done,
   output logic                                weight_clip,
   output logic                                load_error
);

   localparam int IDX_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
   localparam logic [LINK_BIT_WIDTH-1:0] MAX_W = LINK_BIT_WIDTH'(MAX_WEIGHT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINKS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                                 state;
   logic [IDX_W-1:0]                       index;
   logic [NUM_LINKS-1:0][LINK_BIT_WIDTH-1:0] weight_q;
   logic [NUM_LINKS-1:0][1:0]              bc_q;
   logic [NUM_LINKS-1:0]                   erased_q;

   logic [LINK_BIT_WIDTH-1:0] word_weight;
   logic [1:0]                word_bc;
   logic                      word_erased;
   logic                      stage_ok;

   // Clamp an incoming weight field to the largest legal link weight.
   function automatic logic [LINK_BIT_WIDTH-1:0] sat_weight(input logic [LINK_BIT_WIDTH-1:0] w);
      return (w > MAX_W) ? MAX_W : w;
   endfunction

   assign word_weight = in_data[LINK_BIT_WIDTH-1:0];
   assign word_bc     = in_data[LINK_BIT_WIDTH+1:LINK_BIT_WIDTH];
   assign word_erased = in_data[LINK_BIT_WIDTH+2];

   // Words may be pre-staged while the decoder idles or during parameter loading.
   assign stage_ok = (global_stage == STAGE_PARAMETERS_LOADING) ||
                     (global_stage == STAGE_IDLE);

   assign in_ready               = (state == FILL);
   assign weight_out             = weight_q;
   assign boundary_condition_out = bc_q;
   assign erased_out             = erased_q;

   // Fill controller and holding registers; load_start outranks abort, abort outranks writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         index       <= '0;
         weight_q    <= '0;
         bc_q        <= '0;
         erased_q    <= '0;
         load_done   <= 1'b0;
         weight_clip <= 1'b0;
         load_error  <= 1'b0;
      end else if (load_start) begin
         state       <= FILL;
         index       <= '0;
         load_done   <= 1'b0;
         weight_clip <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (!stage_ok) begin
                  state      <= IDLE;
                  load_error <= 1'b1;
               end else if (in_valid) begin
                  weight_q[index] <= sat_weight(word_weight);
                  bc_q[index]     <= word_bc;
                  erased_q[index] <= word_erased;
                  if (word_weight > MAX_W) begin
                     weight_clip <= 1'b1;
                  end
                  if (index == LAST_IDX) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                     index     <= '0;
                  end else begin
                     index <= index + 1'b1;
                  end
               end
            end
            DONE:    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_link_param_loader.sv
// Self-checking bench for link_param_loader: directed scenarios plus a
// randomized phase, all compared against a transaction-level model.
module tb_link_param_loader;

   localparam int N    = 16;
   localparam int LBW  = 2;
   localparam int MAXW = 2;
   localparam int WW   = LBW + 3;
   localparam int SW   = 3;
   localparam logic [SW-1:0] ST_IDLE = 3'd0;
   localparam logic [SW-1:0] ST_MEAS = 3'd2;
   localparam logic [SW-1:0] ST_PL   = 3'd7;

   logic              clk = 1'b0;
   logic              reset;
   logic [SW-1:0]     global_stage;
   logic              load_start;
   logic [WW-1:0]     in_data;
   logic              in_valid;
   logic              in_ready;
   logic [N*LBW-1:0]  weight_out;
   logic [N*2-1:0]    boundary_condition_out;
   logic [N-1:0]      erased_out;
   logic              load_done;
   logic              weight_clip;
   logic              load_error;

   link_param_loader #(
      .NUM_LINKS(N), .MAX_WEIGHT(MAXW), .STAGE_WIDTH(SW),
      .STAGE_IDLE(ST_IDLE), .STAGE_PARAMETERS_LOADING(ST_PL)
   ) dut (
      .clk(clk), .reset(reset), .global_stage(global_stage),
      .load_start(load_start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .weight_out(weight_out),
      .boundary_condition_out(boundary_condition_out), .erased_out(erased_out),
      .load_done(load_done), .weight_clip(weight_clip), .load_error(load_error)
   );

   always #5 clk = ~clk;

   // Reference model: per-link contents plus fill progress.
   int m_w [N];
   int m_bc[N];
   int m_er[N];
   bit m_fill, m_done, m_clip, m_err;
   int m_cnt;

   int checks = 0;
   int errors = 0;

   function automatic logic [WW-1:0] mk(input int w, input int bc, input int er);
      logic [WW-1:0] r;
      r = {1'(er), 2'(bc), LBW'(w)};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_w[i] = 0; m_bc[i] = 0; m_er[i] = 0;
      end
      m_fill = 0; m_done = 0; m_clip = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit st, input bit v, input logic [WW-1:0] d, input logic [SW-1:0] stg);
      int w;
      if (st) begin
         m_fill = 1; m_cnt = 0; m_done = 0; m_clip = 0; m_err = 0;
      end else if (m_fill && !(stg == ST_PL || stg == ST_IDLE)) begin
         m_fill = 0; m_err = 1;
      end else if (m_fill && v) begin
         w = int'(d[LBW-1:0]);
         if (w > MAXW) begin
            w = MAXW; m_clip = 1;
         end
         m_w[m_cnt]  = w;
         m_bc[m_cnt] = int'(d[LBW+1:LBW]);
         m_er[m_cnt] = int'(d[LBW+2]);
         m_cnt++;
         if (m_cnt == N) begin
            m_fill = 0; m_done = 1; m_cnt = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [N*LBW-1:0] ew;
      logic [N*2-1:0]   eb;
      logic [N-1:0]     ee;
      for (int i = 0; i < N; i++) begin
         ew[i*LBW +: LBW] = LBW'(m_w[i]);
         eb[i*2 +: 2]     = 2'(m_bc[i]);
         ee[i]            = 1'(m_er[i]);
      end
      chk({tag, ".weight"}, 64'(weight_out), 64'(ew));
      chk({tag, ".bc"}, 64'(boundary_condition_out), 64'(eb));
      chk({tag, ".erased"}, 64'(erased_out), 64'(ee));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_fill));
      chk({tag, ".load_done"}, 64'(load_done), 64'(m_done));
      chk({tag, ".weight_clip"}, 64'(weight_clip), 64'(m_clip));
      chk({tag, ".load_error"}, 64'(load_error), 64'(m_err));
   endtask

   task automatic cycle(input string tag, input bit st, input bit v, input logic [WW-1:0] d, input logic [SW-1:0] stg);
      load_start = st; in_valid = v; in_data = d; global_stage = stg;
      @(posedge clk);
      model_step(st, v, d, stg);
      #1;
      check_all(tag);
   endtask

   task automatic pattern_fill(input string tag, input int gap_pct);
      int i;
      i = 0;
      while (i < N) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            cycle(tag, 1'b0, 1'b0, WW'($urandom), ($urandom_range(0, 1) != 0) ? ST_PL : ST_IDLE);
         end else begin
            cycle(tag, 1'b0, 1'b1, mk(i % 3, i % 4, i & 1), ST_PL);
            i++;
         end
      end
   endtask

   initial begin
      int r;
      logic [SW-1:0] stg;
      reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0; global_stage = ST_IDLE;
      model_reset();
      #3;
      check_all("reset_init");
      #9 reset = 1'b0;

      // Back-to-back full load
      cycle("b2b_start", 1'b1, 1'b0, '0, ST_PL);
      pattern_fill("b2b", 0);
      chk("b2b_done_level", 64'(load_done), 64'd1);
      chk("b2b_link5_weight", 64'(weight_out[11:10]), 64'd2);
      for (int k = 0; k < 4; k++) cycle("done_hold", 1'b0, 1'b1, mk(1, 1, 1), ST_PL);

      // Async reset in the middle of a fill
      cycle("mid_start", 1'b1, 1'b0, '0, ST_PL);
      for (int k = 0; k < 5; k++) cycle("mid_fill", 1'b0, 1'b1, WW'($urandom), ST_PL);
      load_start = 1'b0; in_valid = 1'b0;
      reset = 1'b1;
      #2;
      model_reset();
      check_all("async_reset");
      #3 reset = 1'b0;
      cycle("idle_after_reset", 1'b0, 1'b1, mk(2, 3, 1), ST_PL);

      // Weight clipping at link 4
      cycle("clip_start", 1'b1, 1'b0, '0, ST_PL);
      for (int k = 0; k < N; k++)
         cycle("clip_fill", 1'b0, 1'b1, (k == 4) ? mk(3, 1, 0) : mk($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1)), ST_PL);
      chk("clip_link4", 64'(weight_out[9:8]), 64'd2);
      chk("clip_sticky", 64'(weight_clip), 64'd1);
      cycle("clip_clear", 1'b1, 1'b0, '0, ST_PL);
      chk("clip_cleared", 64'(weight_clip), 64'd0);

      // Gapped fill reproduces the back-to-back image
      pattern_fill("gaps", 30);
      chk("gaps_done", 64'(load_done), 64'd1);

      // Restart with a valid word at index 7
      cycle("rs_start", 1'b1, 1'b0, '0, ST_PL);
      for (int k = 0; k < 7; k++) cycle("rs_fill", 1'b0, 1'b1, mk(0, 2, 1), ST_IDLE);
      cycle("rs_restart", 1'b1, 1'b1, mk(2, 3, 0), ST_PL);
      chk("rs_link7_kept", 64'(weight_out[15:14]), 64'(m_w[7]));
      cycle("rs_first", 1'b0, 1'b1, mk(1, 1, 0), ST_PL);
      chk("rs_link0", 64'({erased_out[0], boundary_condition_out[1:0], weight_out[1:0]}), 64'(mk(1, 1, 0)));

      // Abort at index 10
      for (int k = 1; k < 10; k++) cycle("ab_fill", 1'b0, 1'b1, mk(2, 0, 1), ST_PL);
      cycle("ab_abort", 1'b0, 1'b1, mk(0, 3, 0), ST_MEAS);
      chk("ab_error", 64'(load_error), 64'd1);
      chk("ab_not_done", 64'(load_done), 64'd0);
      for (int k = 0; k < 3; k++) cycle("ab_idle", 1'b0, 1'b1, WW'($urandom), ST_PL);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 19);
         if (r == 0) stg = SW'($urandom);
         else stg = ($urandom_range(0, 3) == 0) ? ST_IDLE : ST_PL;
         cycle("rand", $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7, WW'($urandom), stg);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/link_param_loader.md
Name: link_param_loader

Overview:
- Transmit side of the link parameter interface. Fills and holds the per-link weight, boundary-condition and erasure values consumed by an array of neighbor links.
- Accepts a valid/ready stream of packed per-link parameter words from the controller and writes them sequentially into NUM_LINKS holding registers.
- Drives the flattened weight_in / boundary_condition_in / erased buses of the link array. Each link latches those buses every cycle of STAGE_PARAMETERS_LOADING, so the outputs must stay stable once loaded.

Parameters:
- NUM_LINKS, 16, number of links driven; index width IDX_W = $clog2(NUM_LINKS) (minimum 1).
- MAX_WEIGHT, 2, largest legal link weight.
- LINK_BIT_WIDTH, $clog2(MAX_WEIGHT+1) (derived localparam), width of one weight field.
- WORD_W, LINK_BIT_WIDTH+3 (derived localparam), stream word = {erased[1], boundary_condition[2], weight[LINK_BIT_WIDTH]}.
- STAGE_WIDTH and stage encodings come from the shared parameters include.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- global_stage  input  STAGE_WIDTH  decoder global stage.
- load_start  input  1  single-cycle pulse: begin (or restart) a fill at link 0.
- in_data  input  WORD_W  packed parameter word for the current link index.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- weight_out  output  NUM_LINKS*LINK_BIT_WIDTH  link i at bits [i*LINK_BIT_WIDTH +: LINK_BIT_WIDTH].
- boundary_condition_out  output  NUM_LINKS*2  link i at [2i +: 2]; 0 none, 1 boundary, 2/3 non-existent.
- erased_out  output  NUM_LINKS  per-link erasure flag.
- load_done  output  1  level: all NUM_LINKS words written since the last load_start.
- weight_clip  output  1  sticky: a weight > MAX_WEIGHT was received and saturated.
- load_error  output  1  sticky: fill aborted because global_stage left STAGE_PARAMETERS_LOADING.

Behaviour:
- Reset (asynchronous, active-high):
  - state IDLE, index 0.
  - All holding registers 0, so every output bus is 0.
  - in_ready, load_done, weight_clip, load_error all 0.
- FSM states IDLE, FILL, DONE. in_ready = (state == FILL), combinational from registered state only.
- IDLE:
  - load_start: go to FILL, index 0, load_done 0, weight_clip 0, load_error 0.
  - Otherwise stay in IDLE.
- FILL:
  - Handshake is in_valid && in_ready. On a handshake, link[index] registers are written on that clock edge.
  - weight is saturated to MAX_WEIGHT when the field exceeds it, and weight_clip sets in the same cycle.
  - boundary_condition and erased are stored unmodified.
  - index increments on each handshake. On the handshake at index == NUM_LINKS-1: go to DONE, set load_done, index wraps to 0.
  - If in_valid is low, nothing changes (no timeout).
- DONE:
  - Registers held indefinitely; load_done stays 1; in_ready 0.
  - load_start returns to FILL as from IDLE. Holding registers keep their old values until overwritten word by word.
- Priority within one cycle, highest first:
  1. reset.
  2. load_start: restarts to FILL at index 0. Any word presented in that cycle is dropped, with no register write even if in_valid && in_ready.
  3. Abort: in FILL, if global_stage != STAGE_PARAMETERS_LOADING and global_stage != STAGE_IDLE, go to IDLE and set load_error. Any handshake in that cycle is dropped; already-written links keep their values.
  4. Normal handshake.
- Words are accepted while global_stage is STAGE_IDLE (pre-staging) or STAGE_PARAMETERS_LOADING.
- Latency: a word accepted at edge N appears on the output buses after edge N. load_done rises on the same edge as the last write.
- Throughput: one word per cycle; the full load takes exactly NUM_LINKS handshake cycles.
- Outputs never change outside FILL handshakes and reset.

Test Plan:
- Reset mid-FILL after 5 words -> all buses 0, in_ready 0, load_done 0 immediately (asynchronous, before the next clk edge).
- load_start, then 16 back-to-back words with weight=i%3, bc=i%4, erased=i[0], stage=PARAMETERS_LOADING -> buses match per link, load_done on the 16th edge, in_ready low after.
- Word with weight field 3 (MAX_WEIGHT=2, LINK_BIT_WIDTH=2) at link 4 -> weight_out[9:8]=2, weight_clip=1 sticky until next load_start.
- Random in_valid gaps (30% idle) -> same final buses as the back-to-back case; index advances only on handshakes.
- load_start asserted with a valid word at index 7 -> word dropped, index 0; the next accepted word lands in link 0; links 0-6 keep their old values until rewritten.
- Stage switches to STAGE_MEASUREMENT_LOADING at index 10 -> state IDLE, load_error=1, load_done=0, links 0-9 retain their new values, links 10-15 retain their old values.
